// File: rtl/pipeline_sequencer_pkg.sv
// Shared pipeline definitions: sequencer states, RV64 major opcodes and the
// zero-register index, plus the source/producer match helper.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } seq_state_e;

  localparam logic [4:0] X0 = 5'd0;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;

  // x0 never carries a dependency, so a producer writing x0 cannot match.
  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] rd);
    return use_src && (src == rd) && (rd != X0);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Combinational load-use / branch-source hazard detection and redirect
// qualification for the ID stage.
module pipeline_sequencer_hazard_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_branch,
  input  logic       id_jalr,
  input  logic       id_jal,
  input  logic       id_taken,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_load,
  output logic       hazard,
  output logic       redirect
);

  logic ex_match;
  logic mem_match;
  logic resolves_in_id;

  assign ex_match  = src_match(id_use_rs1, id_rs1, ex_rd)  || src_match(id_use_rs2, id_rs2, ex_rd);
  assign mem_match = src_match(id_use_rs1, id_rs1, mem_rd) || src_match(id_use_rs2, id_rs2, mem_rd);
  assign resolves_in_id = id_branch || id_jalr;

  // Branches compare in ID, so they also wait on ALU results still in EX
  // and on load data that has not left MEM yet.
  assign hazard = (ex_load && ex_match)
               || (resolves_in_id && ex_reg_write && ex_match)
               || (resolves_in_id && mem_load && mem_match);

  assign redirect = ((id_branch && id_taken) || id_jal || id_jalr) && !hazard;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: reset hold, hazard stalls,
// ID-stage redirects, data-memory waits with timeout, and perf counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_branch_i,
  input  logic             id_jalr_i,
  input  logic             id_jal_i,
  input  logic             id_taken_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_load_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_load_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             mem_wb_bubble_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // RESET_HOLD must be at least 1.
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  seq_state_e        state, state_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              halt;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              hazard, redirect;
  logic              mem_blocked, stall_inc, flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != '1)) return cnt + 1'b1;
    return cnt;
  endfunction

  pipeline_sequencer_hazard_detect u_hazard (
    .id_rs1       (id_rs1_i),
    .id_rs2       (id_rs2_i),
    .id_use_rs1   (id_use_rs1_i),
    .id_use_rs2   (id_use_rs2_i),
    .id_branch    (id_branch_i),
    .id_jalr      (id_jalr_i),
    .id_jal       (id_jal_i),
    .id_taken     (id_taken_i),
    .ex_rd        (ex_rd_i),
    .ex_reg_write (ex_reg_write_i),
    .ex_load      (ex_load_i),
    .mem_rd       (mem_rd_i),
    .mem_load     (mem_load_i),
    .hazard       (hazard),
    .redirect     (redirect)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_HOLD;
      hold_cnt  <= HOLD_INIT;
      wait_cnt  <= '0;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      wait_cnt  <= wait_nx;
      halt      <= (state_nx == ST_HALT);
      stall_cnt <= sat_inc(stall_cnt, stall_inc);
      flush_cnt <= sat_inc(flush_cnt, flush_inc);
    end
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    wait_nx  = wait_cnt;
    case (state)
      ST_HOLD: begin
        if (hold_cnt == '0) state_nx = ST_RUN;
        else                hold_nx  = hold_cnt - 1'b1;
      end
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_nx = ST_MEM_WAIT;
          wait_nx  = '0;
        end
      end
      ST_MEM_WAIT: begin
        // A completion arriving on the last allowed cycle still wins.
        if (mem_ready_i)                state_nx = ST_RUN;
        else if (wait_cnt == WAIT_LAST) state_nx = ST_HALT;
        else                            wait_nx  = wait_cnt + 1'b1;
      end
      default: state_nx = ST_HALT;
    endcase
  end

  always_comb begin
    pc_en_o         = 1'b0;
    if_id_en_o      = 1'b0;
    id_ex_en_o      = 1'b0;
    ex_mem_en_o     = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_bubble_o  = 1'b1;
    mem_wb_bubble_o = 1'b1;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    mem_blocked     = (state == ST_RUN) ? (mem_req_i && !mem_ready_i) : !mem_ready_i;
    if ((state == ST_RUN) || (state == ST_MEM_WAIT)) begin
      id_ex_bubble_o  = 1'b0;
      mem_wb_bubble_o = 1'b0;
      if (mem_blocked) begin
        mem_wb_bubble_o = 1'b1;
        stall_inc       = 1'b1;
      end else if (hazard) begin
        id_ex_en_o     = 1'b1;
        ex_mem_en_o    = 1'b1;
        id_ex_bubble_o = 1'b1;
        stall_inc      = 1'b1;
      end else begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        if_id_flush_o = redirect;
        flush_inc     = redirect;
      end
    end
  end

  assign halt_o      = halt;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: reset hold, load-use and branch
// stalls, redirects, memory waits, timeout halt and counter saturation.
module tb_pipeline_sequencer;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset_n_i;
  logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i;
  logic             id_use_rs1_i, id_use_rs2_i, id_branch_i, id_jalr_i, id_jal_i, id_taken_i;
  logic             ex_reg_write_i, ex_load_i, mem_load_i, mem_req_i, mem_ready_i;
  logic             pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o;
  logic             if_id_flush_o, id_ex_bubble_o, mem_wb_bubble_o, halt_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [6:0]       ctl;

  int tests = 0;
  int fails = 0;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble}
  localparam logic [6:0] C_HOLD = 7'b0000_011;
  localparam logic [6:0] C_RUN  = 7'b1111_000;
  localparam logic [6:0] C_HAZ  = 7'b0011_010;
  localparam logic [6:0] C_REDR = 7'b1111_100;
  localparam logic [6:0] C_MEMW = 7'b0000_001;

  always #5 clk = ~clk;

  assign ctl = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
                if_id_flush_o, id_ex_bubble_o, mem_wb_bubble_o};

  pipeline_sequencer #(.RESET_HOLD(2), .MEM_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_branch_i(id_branch_i), .id_jalr_i(id_jalr_i), .id_jal_i(id_jal_i),
    .id_taken_i(id_taken_i),
    .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i), .ex_load_i(ex_load_i),
    .mem_rd_i(mem_rd_i), .mem_load_i(mem_load_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .id_ex_en_o(id_ex_en_o),
    .ex_mem_en_o(ex_mem_en_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_bubble_o(id_ex_bubble_o), .mem_wb_bubble_o(mem_wb_bubble_o),
    .halt_o(halt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
    id_branch_i = 1'b0; id_jalr_i = 1'b0; id_jal_i = 1'b0; id_taken_i = 1'b0;
    ex_rd_i = 5'd0; ex_reg_write_i = 1'b0; ex_load_i = 1'b0;
    mem_rd_i = 5'd0; mem_load_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first RUN cycle, one time unit past posedge+1.
  task automatic do_reset();
    idle();
    reset_n_i = 1'b0;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_HOLD));
    chk("rst_halt", 32'(halt_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
    chk("rst_flush", 32'(flush_cnt_o), 32'd0);
    tick();
    reset_n_i = 1'b1;
    #1;
    chk("hold1_ctl", 32'(ctl), 32'(C_HOLD));
    tick(); #1;
    chk("hold2_ctl", 32'(ctl), 32'(C_HOLD));
    tick(); #1;
    chk("run3_ctl", 32'(ctl), 32'(C_RUN));
  endtask

  task automatic ex_ld_x5();
    ex_rd_i = 5'd5; ex_load_i = 1'b1; ex_reg_write_i = 1'b1;
  endtask

  initial begin
    idle();
    reset_n_i = 1'b0;

    // Reset and post-reset hold
    do_reset();

    // Load-use: ld x5 in EX, add x6,x5,x1 in ID
    ex_ld_x5();
    id_rs1_i = 5'd5; id_rs2_i = 5'd1; id_use_rs1_i = 1'b1; id_use_rs2_i = 1'b1;
    #1; chk("lu_stall_ctl", 32'(ctl), 32'(C_HAZ));
    tick();
    idle();
    mem_rd_i = 5'd5; mem_load_i = 1'b1; mem_req_i = 1'b1; mem_ready_i = 1'b1;
    id_rs1_i = 5'd5; id_rs2_i = 5'd1; id_use_rs1_i = 1'b1; id_use_rs2_i = 1'b1;
    #1; chk("lu_release_ctl", 32'(ctl), 32'(C_RUN));
    chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
    tick(); idle(); #1;
    chk("lu_stall_cnt_hold", 32'(stall_cnt_o), 32'd1);

    // Load then taken beq x5,x0: two stalls, then redirect
    do_reset();
    ex_ld_x5();
    id_rs1_i = 5'd5; id_use_rs1_i = 1'b1; id_use_rs2_i = 1'b1;
    id_branch_i = 1'b1; id_taken_i = 1'b1;
    #1; chk("br_stall1_ctl", 32'(ctl), 32'(C_HAZ));
    tick();
    ex_rd_i = 5'd0; ex_load_i = 1'b0; ex_reg_write_i = 1'b0;
    mem_rd_i = 5'd5; mem_load_i = 1'b1; mem_req_i = 1'b1; mem_ready_i = 1'b1;
    #1; chk("br_stall2_ctl", 32'(ctl), 32'(C_HAZ));
    chk("br_stall_cnt1", 32'(stall_cnt_o), 32'd1);
    tick();
    mem_rd_i = 5'd0; mem_load_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
    #1; chk("br_redirect_ctl", 32'(ctl), 32'(C_REDR));
    chk("br_stall_cnt2", 32'(stall_cnt_o), 32'd2);
    chk("br_flush_cnt0", 32'(flush_cnt_o), 32'd0);
    tick();
    id_taken_i = 1'b0;
    #1; chk("br_not_taken_ctl", 32'(ctl), 32'(C_RUN));
    chk("br_flush_cnt1", 32'(flush_cnt_o), 32'd1);
    tick(); idle();

    // JALR whose base is written by an ALU op in EX: stall, then redirect
    id_jalr_i = 1'b1; id_rs1_i = 5'd7; id_use_rs1_i = 1'b1;
    ex_rd_i = 5'd7; ex_reg_write_i = 1'b1;
    #1; chk("jalr_stall_ctl", 32'(ctl), 32'(C_HAZ));
    tick();
    ex_rd_i = 5'd0; ex_reg_write_i = 1'b0;
    #1; chk("jalr_redirect_ctl", 32'(ctl), 32'(C_REDR));
    chk("jalr_stall_cnt", 32'(stall_cnt_o), 32'd3);
    tick(); idle();
    id_jal_i = 1'b1;
    #1; chk("jal_redirect_ctl", 32'(ctl), 32'(C_REDR));
    chk("jalr_flush_cnt", 32'(flush_cnt_o), 32'd2);
    tick(); idle();
    // ALU producer in EX feeding a non-branch consumer is forwarded, no stall
    id_rs1_i = 5'd7; id_use_rs1_i = 1'b1; ex_rd_i = 5'd7; ex_reg_write_i = 1'b1;
    #1; chk("alu_fwd_ctl", 32'(ctl), 32'(C_RUN));
    chk("jal_flush_cnt", 32'(flush_cnt_o), 32'd3);
    tick(); idle();

    // rd = x0 producers never stall
    do_reset();
    ex_rd_i = 5'd0; ex_load_i = 1'b1; ex_reg_write_i = 1'b1;
    id_rs1_i = 5'd0; id_use_rs1_i = 1'b1; id_branch_i = 1'b1;
    mem_rd_i = 5'd0; mem_load_i = 1'b1;
    #1; chk("x0_no_stall_ctl", 32'(ctl), 32'(C_RUN));
    tick(); idle(); #1;
    chk("x0_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Memory wait of 5 cycles, coinciding with a load-use hazard at first
    do_reset();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    ex_ld_x5(); id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
    #1; chk("mw_c1_ctl", 32'(ctl), 32'(C_MEMW));
    tick();
    idle(); mem_req_i = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1; chk($sformatf("mw_c%0d_ctl", i), 32'(ctl), 32'(C_MEMW));
      tick();
    end
    mem_ready_i = 1'b1; id_jal_i = 1'b1;
    #1; chk("mw_done_ctl", 32'(ctl), 32'(C_REDR));
    chk("mw_stall_cnt", 32'(stall_cnt_o), 32'd5);
    tick(); idle();
    #1; chk("mw_after_ctl", 32'(ctl), 32'(C_RUN));
    chk("mw_after_stall", 32'(stall_cnt_o), 32'd5);
    chk("mw_after_flush", 32'(flush_cnt_o), 32'd1);

    // Ready on the final allowed wait cycle: no halt
    do_reset();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 63; i++) tick();
    mem_ready_i = 1'b1;
    #1; chk("to_edge_ready_ctl", 32'(ctl), 32'(C_RUN));
    tick(); idle(); #1;
    chk("to_edge_halt", 32'(halt_o), 32'd0);
    chk("to_edge_run_ctl", 32'(ctl), 32'(C_RUN));

    // Memory never ready: halt after 64 wait cycles, counter saturates
    do_reset();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    #1; chk("to_c1_ctl", 32'(ctl), 32'(C_MEMW));
    tick();
    for (int i = 0; i < 63; i++) tick();
    #1; chk("to_pre_halt", 32'(halt_o), 32'd0);
    chk("to_pre_ctl", 32'(ctl), 32'(C_MEMW));
    tick(); #1;
    chk("to_halt", 32'(halt_o), 32'd1);
    chk("to_halt_ctl", 32'(ctl), 32'(C_HOLD));
    chk("to_stall_sat", 32'(stall_cnt_o), 32'h3f);
    mem_ready_i = 1'b1;
    tick(); tick(); tick(); #1;
    chk("to_halt_sticky", 32'(halt_o), 32'd1);
    chk("to_halt_sticky_ctl", 32'(ctl), 32'(C_HOLD));
    chk("to_stall_sat_hold", 32'(stall_cnt_o), 32'h3f);
    do_reset();
    chk("to_reset_clears_halt", 32'(halt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
